alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter MC_LATENCY, default 3, meaning the pipeline depth of the ALU's multiply and divide units; legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: the requester presents an operation.
REQ-005 SHALL have port req_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 SHALL have port req_aluop, input, 4 bits: the operation as lc3b_aluop; alu_mul and alu_div are multi-cycle, all other codes are single-cycle.
REQ-007 SHALL have ports req_a and req_b, input, 16 bits each: the operands as lc3b_word.
REQ-008 SHALL have port alu_aluop, output, 4 bits: the registered operation driven into the ALU.
REQ-009 SHALL have ports alu_a and alu_b, output, 16 bits each: the registered operands driven into the ALU.
REQ-010 SHALL have port alu_f, input, 16 bits: the ALU result.
REQ-011 SHALL have port rsp_valid, output, 1 bit: the response is available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rsp_f, output, 16 bits: the registered result.
REQ-014 SHALL have port rsp_err, output, 1 bit: divide-by-zero flag (see Configuration).
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, EXEC, WAIT and DONE.
REQ-017 SHALL drive req_ready = 1 only in IDLE; an operation is accepted at an edge where req_valid && req_ready is true.
REQ-018 On accept, SHALL register req_aluop, req_a and req_b into alu_aluop, alu_a and alu_b, and SHALL hold them stable until the next accept.
REQ-019 On accepting a single-cycle op, SHALL go IDLE->EXEC; at the next edge it SHALL capture alu_f into rsp_f and go EXEC->DONE, giving rsp_valid 2 edges after accept.
REQ-020 On accepting a multi-cycle op, SHALL go IDLE->WAIT and load a 3-bit counter with MC_LATENCY.
REQ-021 In WAIT, SHALL decrement the counter each edge; at the edge where the counter equals 1, it SHALL capture alu_f into rsp_f and go to DONE, giving rsp_valid MC_LATENCY+1 edges after accept.
REQ-022 In DONE, SHALL hold rsp_valid = 1 and keep rsp_f and rsp_err stable until rsp_valid && rsp_ready, then go DONE->IDLE.
REQ-023 SHALL NOT accept a new request in the cycle a response handshakes (no bypass); req_ready rises the cycle after DONE->IDLE.
REQ-024 SHALL ignore req_valid, req_aluop, req_a and req_b in every state other than IDLE.
REQ-025 SHALL treat unassigned aluop codes 12..15 as single-cycle and pass them to the ALU unchanged.
REQ-026 SHALL allow rsp_ready to be held high continuously; the response still lasts at least one cycle in DONE.

Reset
REQ-027 On rst_n low, SHALL immediately force: state IDLE, counter 0, alu_aluop/alu_a/alu_b 0, rsp_f 0, rsp_err 0, rsp_valid 0, busy 0; req_ready SHALL be 1 after reset.
REQ-028 Reset mid-operation (EXEC, WAIT or DONE) SHALL discard the operation; no response SHALL be produced for it.

Configuration
REQ-029 With macro ALU_DIV0_TRAP_EN defined, SHALL route an accepted alu_div with req_b == 0 via EXEC (not WAIT), set rsp_f = 16'hFFFF and rsp_err = 1, and still drive the operands into the ALU.
REQ-030 Without ALU_DIV0_TRAP_EN, SHALL handle a divide by zero as a normal multi-cycle op, take rsp_f from alu_f, and tie rsp_err to 0.
REQ-031 SHALL clear rsp_err to 0 for every response other than a trapped divide by zero.

Verification
REQ-032 Accept alu_add with a=16'h0003, b=16'h0004 -> rsp_valid at accept+2 edges, rsp_f=16'h0007, rsp_err=0.
REQ-033 Accept alu_mul with a=16'h0006, b=16'h0007 (MC_LATENCY=3) -> busy for 4 cycles, rsp_valid at accept+4 edges, rsp_f=16'h002A; req_valid held high meanwhile is not accepted.
REQ-034 Complete an alu_xor, hold rsp_ready=0 for 5 cycles then 1 -> rsp_f stable throughout, req_ready=0 until the cycle after the handshake.
REQ-035 With ALU_DIV0_TRAP_EN, accept alu_div with a=16'h0010, b=0 -> rsp_valid at accept+2 edges, rsp_f=16'hFFFF, rsp_err=1; without the macro, rsp_valid at accept+4 edges and rsp_err=0.
REQ-036 Assert rst_n=0 while in WAIT during an alu_div -> all outputs at reset values immediately, no rsp_valid after release, and the next alu_sub with a=5, b=2 returns 16'h0003.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequencer that registers one operation at a time into an external
// ALU, waits one cycle for single-cycle ops or MC_LATENCY cycles for the
// multiply/divide units, and holds the registered result until the consumer
// takes it.
// Optional feature macro: ALU_DIV0_TRAP_EN (trap divide-by-zero locally with
// rsp_f = 16'hFFFF and rsp_err = 1 instead of using the ALU result).
module alu_seq #(
  parameter int unsigned MC_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_aluop,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [3:0]  alu_aluop,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_f,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_f,
  output logic        rsp_err,
  output logic        busy
);

  // lc3b_aluop codes that use the pipelined multiply/divide units
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_DIV = 4'd11;
  localparam logic [2:0] MC_LOAD = 3'(MC_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] f_q, f_d;
  logic        accept;
  logic        is_mc;

  assign accept = req_valid && (state_q == S_IDLE);

`ifdef ALU_DIV0_TRAP_EN
  logic err_q, err_d;
  logic trap_q, trap_d;
  logic div0;

  assign div0  = (req_aluop == ALU_DIV) && (req_b == 16'h0000);
  assign is_mc = ((req_aluop == ALU_MUL) || (req_aluop == ALU_DIV)) && !div0;
`else
  assign is_mc = (req_aluop == ALU_MUL) || (req_aluop == ALU_DIV);
`endif

  // Next-state, counter and result-capture logic
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
`ifdef ALU_DIV0_TRAP_EN
    err_d   = err_q;
    trap_d  = trap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mc) begin
            state_d = S_WAIT;
            cnt_d   = MC_LOAD;
          end else begin
            state_d = S_EXEC;
          end
`ifdef ALU_DIV0_TRAP_EN
          trap_d = div0;
`endif
        end
      end
      S_EXEC: begin
        f_d     = alu_f;
`ifdef ALU_DIV0_TRAP_EN
        err_d   = 1'b0;
        if (trap_q) begin
          f_d   = 16'hFFFF;
          err_d = 1'b1;
        end
`endif
        state_d = S_DONE;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          f_d     = alu_f;
`ifdef ALU_DIV0_TRAP_EN
          err_d   = 1'b0;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      f_q     <= 16'h0000;
`ifdef ALU_DIV0_TRAP_EN
      err_q   <= 1'b0;
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
`ifdef ALU_DIV0_TRAP_EN
      err_q   <= err_d;
      trap_q  <= trap_d;
`endif
    end
  end

  // Operand registers feeding the ALU, loaded only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 4'd0;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
    end else if (accept) begin
      op_q <= req_aluop;
      a_q  <= req_a;
      b_q  <= req_b;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign alu_aluop = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_f     = f_q;
`ifdef ALU_DIV0_TRAP_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
